// File: rtl/fir_pkg.sv
// Shared constants, Q15 coefficient table and FSM state type for the
// two-channel time-multiplexed FIR.
package fir_pkg;

  localparam int NTAPS   = 32;
  localparam int NUNIQUE = 16;
  localparam int ACC_W   = 38;

  localparam int SAT_W   = 16;
  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  // Left half of a symmetric 32-tap filter; taps k and 31-k share coefficient k.
  localparam logic signed [15:0] COEFF [0:NUNIQUE-1] = '{
    16'sd0,     -16'sd3,    16'sd11,    -16'sd27,
    16'sd39,    -16'sd11,   -16'sd98,   16'sd277,
    -16'sd392,  16'sd203,   16'sd471,   -16'sd1475,
    16'sd2137,  -16'sd1328, -16'sd2638, 16'sd19218
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_SCALE,
    S_OUT
  } state_t;

endpackage

// File: rtl/fir_delay_line.sv
// One channel's tap storage: shift register with a folded read port that
// returns taps[idx] + taps[NTAPS-1-idx] at full precision.
module fir_delay_line #(
  parameter int NTAPS = 32,
  parameter int DW    = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        shift_en,
  input  logic signed [DW-1:0]        din,
  input  logic [$clog2(NTAPS)-2:0]    rd_idx,
  output logic signed [DW:0]          pair_sum
);

  localparam int AW = $clog2(NTAPS);

  logic signed [DW-1:0] taps [NTAPS];
  logic [AW-1:0]        lo_idx;
  logic [AW-1:0]        hi_idx;

  assign lo_idx   = {1'b0, rd_idx};
  assign hi_idx   = AW'(NTAPS - 1) - lo_idx;
  assign pair_sum = {taps[lo_idx][DW-1], taps[lo_idx]}
                  + {taps[hi_idx][DW-1], taps[hi_idx]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NTAPS; i++) taps[i] <= '0;
    end else if (shift_en) begin
      taps[0] <= din;
      for (int i = 1; i < NTAPS; i++) taps[i] <= taps[i-1];
    end
  end

endmodule

// File: rtl/fir_tdm_scheduler.sv
// Two-channel symmetric FIR sharing one pre-added 17x16 multiplier and a
// 38-bit accumulator; channels are granted round-robin, one result at a time.
module fir_tdm_scheduler #(
  parameter int NTAPS = 32,
  parameter int DW    = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic signed [DW-1:0] ch0_x,
  input  logic                 ch0_valid,
  output logic                 ch0_ready,
  input  logic signed [DW-1:0] ch1_x,
  input  logic                 ch1_valid,
  output logic                 ch1_ready,
  output logic signed [DW-1:0] y_out,
  output logic                 y_ch,
  output logic                 y_valid,
  input  logic                 y_ready,
  output logic                 busy
);

  import fir_pkg::state_t;
  import fir_pkg::S_IDLE;
  import fir_pkg::S_MAC;
  import fir_pkg::S_SCALE;
  import fir_pkg::S_OUT;
  import fir_pkg::COEFF;
  import fir_pkg::ACC_W;
  import fir_pkg::SAT_MAX;
  import fir_pkg::SAT_MIN;

  localparam int KW = $clog2(NTAPS) - 1;
  localparam int CW = $clog2(NTAPS + 1);

  function automatic logic signed [DW-1:0] sat16(input logic signed [ACC_W-1:0] v);
    if (v > ACC_W'(SAT_MAX))      return DW'(SAT_MAX);
    else if (v < ACC_W'(SAT_MIN)) return DW'(SAT_MIN);
    else                          return v[DW-1:0];
  endfunction

  state_t                  state;
  logic [KW-1:0]           k;
  logic                    sel_ch;
  logic                    rr_last;
  logic [CW-1:0]           fill0;
  logic [CW-1:0]           fill1;
  logic signed [ACC_W-1:0] acc;

  logic                    grant;
  logic                    idle_ok;
  logic [CW-1:0]           fill_cur;
  logic [CW-1:0]           fill_nxt;
  logic signed [DW:0]      pair0;
  logic signed [DW:0]      pair1;
  logic signed [DW:0]      pair_sel;
  logic signed [15:0]      coeff_k;
  logic signed [DW+16:0]   prod;
  logic signed [ACC_W-1:0] acc_sh;

  // Sole requester wins; on a tie the channel not served last wins.
  always_comb begin
    grant = 1'b0;
    if (ch0_valid && ch1_valid) grant = ~rr_last;
    else if (ch1_valid)         grant = 1'b1;
  end

  assign idle_ok   = reset_n && (state == S_IDLE);
  assign ch0_ready = idle_ok && ch0_valid && !grant;
  assign ch1_ready = idle_ok && ch1_valid && grant;
  assign busy      = (state != S_IDLE);

  assign fill_cur = grant ? fill1 : fill0;
  assign fill_nxt = (fill_cur == CW'(NTAPS)) ? fill_cur : fill_cur + 1'b1;

  fir_delay_line #(.NTAPS(NTAPS), .DW(DW)) u_line0 (
    .clk      (clk),
    .reset_n  (reset_n),
    .shift_en (ch0_ready),
    .din      (ch0_x),
    .rd_idx   (k),
    .pair_sum (pair0)
  );

  fir_delay_line #(.NTAPS(NTAPS), .DW(DW)) u_line1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .shift_en (ch1_ready),
    .din      (ch1_x),
    .rd_idx   (k),
    .pair_sum (pair1)
  );

  assign pair_sel = sel_ch ? pair1 : pair0;
  assign coeff_k  = COEFF[k];
  assign prod     = pair_sel * coeff_k;
  assign acc_sh   = acc >>> 15;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      k       <= '0;
      sel_ch  <= 1'b0;
      rr_last <= 1'b1;
      fill0   <= '0;
      fill1   <= '0;
      acc     <= '0;
      y_out   <= '0;
      y_ch    <= 1'b0;
      y_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ch0_ready || ch1_ready) begin
            rr_last <= grant;
            sel_ch  <= grant;
            if (grant) fill1 <= fill_nxt;
            else       fill0 <= fill_nxt;
            if (fill_nxt == CW'(NTAPS)) begin
              state <= S_MAC;
              k     <= '0;
              acc   <= '0;
            end
          end
        end
        // Folded MAC: one symmetric tap pair per cycle.
        S_MAC: begin
          acc <= acc + ACC_W'(prod);
          k   <= k + 1'b1;
          if (k == KW'(NTAPS/2 - 1)) state <= S_SCALE;
        end
        S_SCALE: begin
          y_out   <= sat16(acc_sh);
          y_ch    <= sel_ch;
          y_valid <= 1'b1;
          state   <= S_OUT;
        end
        S_OUT: begin
          if (y_ready) begin
            y_valid <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tdm_scheduler.sv
// Directed + randomized bench for fir_tdm_scheduler against a direct-form
// 32-tap reference model with per-channel history and a result queue.
module tb_fir_tdm_scheduler;

  logic               clk = 1'b0;
  logic               reset_n;
  logic signed [15:0] ch0_x;
  logic               ch0_valid;
  logic               ch0_ready;
  logic signed [15:0] ch1_x;
  logic               ch1_valid;
  logic               ch1_ready;
  logic signed [15:0] y_out;
  logic               y_ch;
  logic               y_valid;
  logic               y_ready;
  logic               busy;

  fir_tdm_scheduler #(.NTAPS(32), .DW(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ch0_x     (ch0_x),
    .ch0_valid (ch0_valid),
    .ch0_ready (ch0_ready),
    .ch1_x     (ch1_x),
    .ch1_valid (ch1_valid),
    .ch1_ready (ch1_ready),
    .y_out     (y_out),
    .y_ch      (y_ch),
    .y_valid   (y_valid),
    .y_ready   (y_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int y;
    int due;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   n_out = 0;
  int   n_viol = 0;
  int   n_busy_err = 0;
  int   n_stab_err = 0;
  int   last_y = 0;
  int   last_ch = 0;
  int   last_acc = -1;
  int   prev_y = 0;
  int   prev_ch = 0;
  bit   m_busy = 0;
  bit   chk_alt = 0;
  bit   prev_yv = 0;
  bit   prev_yr = 0;
  int   hist [2][32];
  int   fill [2];
  int   coef_half [16] = '{0, -3, 11, -27, 39, -11, -98, 277,
                           -392, 203, 471, -1475, 2137, -1328, -2638, 19218};

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic int coef_full(input int i);
    return (i < 16) ? coef_half[i] : coef_half[31-i];
  endfunction

  function automatic int ref_y(input int ch);
    longint s = 0;
    for (int i = 0; i < 32; i++) s += longint'(hist[ch][i]) * longint'(coef_full(i));
    s = s >>> 15;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      fill[c] = 0;
      for (int i = 0; i < 32; i++) hist[c][i] = 0;
    end
    exp_q.delete();
    m_busy  = 0;
    prev_yv = 0;
    prev_yr = 0;
  endtask

  task automatic model_accept(input int ch, input int x);
    exp_t e;
    for (int i = 31; i > 0; i--) hist[ch][i] = hist[ch][i-1];
    hist[ch][0] = x;
    if (fill[ch] < 32) fill[ch]++;
    if (fill[ch] == 32) begin
      e.ch  = ch;
      e.y   = ref_y(ch);
      e.due = cyc + 18;
      exp_q.push_back(e);
      m_busy = 1;
    end
    last_acc = ch;
  endtask

  // Called at a falling edge with inputs set; observes, models the coming edge.
  task automatic step();
    exp_t e;
    #1;
    if (ch0_ready && ch1_ready) n_viol++;
    if ((ch0_ready || ch1_ready) && m_busy) n_viol++;
    if (busy !== m_busy) n_busy_err++;
    if (y_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_y_valid", 1, 0);
      end else begin
        if (!prev_yv) check("latency", cyc, exp_q[0].due);
        else if (!prev_yr && (y_out !== prev_y || y_ch !== prev_ch)) n_stab_err++;
        if (y_ready) begin
          e = exp_q.pop_front();
          check("y_out", y_out, e.y);
          check("y_ch", y_ch, e.ch);
          if (chk_alt) check("alternate", y_ch, 1 - last_ch);
          last_y  = y_out;
          last_ch = y_ch;
          n_out++;
          m_busy = 0;
        end
      end
    end
    prev_yv = y_valid;
    prev_yr = y_ready;
    prev_y  = y_out;
    prev_ch = y_ch;
    if (ch0_ready)      model_accept(0, ch0_x);
    else if (ch1_ready) model_accept(1, ch1_x);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input int ch, input int x);
    int w = 0;
    if (ch == 0) begin ch0_x = 16'(x); ch0_valid = 1'b1; end
    else         begin ch1_x = 16'(x); ch1_valid = 1'b1; end
    last_acc = -1;
    while (last_acc != ch && w < 200) begin step(); w++; end
    check("send_accepted", last_acc, ch);
    if (ch == 0) ch0_valid = 1'b0;
    else         ch1_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() > 0 && w < 300) begin step(); w++; end
    check("drain_empty", exp_q.size(), 0);
  endtask

  function automatic int rnd16();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  initial begin
    int base;
    int w;
    reset_n   = 1'b0;
    ch0_x     = '0;
    ch1_x     = '0;
    ch0_valid = 1'b1;
    ch1_valid = 1'b1;
    y_ready   = 1'b1;
    model_reset();

    // Reset state, with requests pending
    @(negedge clk); #1;
    check("rst_ch0_ready", ch0_ready, 0);
    check("rst_ch1_ready", ch1_ready, 0);
    check("rst_y_valid", y_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_y_out", y_out, 0);
    check("rst_y_ch", y_ch, 0);
    ch0_valid = 1'b0;
    ch1_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // DC fill on ch0
    for (int i = 0; i < 31; i++) send(0, 10000);
    check("dc_no_early_out", n_out, 0);
    send(0, 10000);
    drain();
    check("dc_count", n_out, 1);
    check("dc_value", last_y, 10000);
    check("dc_ch", last_ch, 0);

    // Impulse on ch1
    for (int i = 0; i < 16; i++) send(1, 0);
    send(1, 16384);
    for (int i = 0; i < 15; i++) send(1, 0);
    drain();
    check("imp_count", n_out, 2);
    check("imp_value", last_y, 9609);
    check("imp_ch", last_ch, 1);

    // Saturation, both polarities
    for (int j = 0; j < 32; j++)
      send(0, (coef_full(j) > 0) ? 32767 : (coef_full(j) < 0) ? -32768 : 0);
    drain();
    check("sat_pos", last_y, 32767);
    for (int j = 0; j < 32; j++)
      send(0, (coef_full(j) > 0) ? -32768 : (coef_full(j) < 0) ? 32767 : 0);
    drain();
    check("sat_neg", last_y, -32768);

    // Contention with both producers always valid
    base      = n_out;
    chk_alt   = 1;
    ch0_x     = 16'(rnd16());
    ch1_x     = 16'(rnd16());
    ch0_valid = 1'b1;
    ch1_valid = 1'b1;
    for (int c = 0; c < 240; c++) begin
      last_acc = -1;
      step();
      if (last_acc == 0) ch0_x = 16'(rnd16());
      if (last_acc == 1) ch1_x = 16'(rnd16());
    end
    ch0_valid = 1'b0;
    ch1_valid = 1'b0;
    drain();
    chk_alt = 0;
    check("cont_enough_results", (n_out - base) >= 12, 1);
    check("cont_ready_viol", n_viol, 0);
    check("cont_busy", n_busy_err, 0);

    // Backpressure with a competing request held
    y_ready = 1'b0;
    send(0, rnd16());
    ch1_x     = 16'(rnd16());
    ch1_valid = 1'b1;
    repeat (68) step();
    check("bp_valid_held", y_valid, 1);
    check("bp_ch", y_ch, 0);
    check("bp_stable", n_stab_err, 0);
    check("bp_ready_viol", n_viol, 0);
    y_ready  = 1'b1;
    last_acc = -1;
    w = 0;
    while (last_acc != 1 && w < 100) begin step(); w++; end
    check("bp_ch1_accepted", last_acc, 1);
    ch1_valid = 1'b0;
    drain();

    // Reset in the middle of a MAC
    send(0, rnd16());
    repeat (5) step();
    #2;
    reset_n   = 1'b0;
    ch0_valid = 1'b1;
    #1;
    check("rst2_y_valid", y_valid, 0);
    check("rst2_busy", busy, 0);
    check("rst2_ch0_ready", ch0_ready, 0);
    model_reset();
    @(negedge clk);
    reset_n   = 1'b1;
    ch0_valid = 1'b0;
    base = n_out;
    repeat (40) step();
    check("rst2_no_out", n_out, base);
    for (int i = 0; i < 31; i++) send(0, rnd16());
    check("rst2_refill_no_out", n_out, base);
    send(0, rnd16());
    drain();
    check("rst2_refill_out", n_out, base + 1);
    check("final_busy", n_busy_err, 0);
    check("final_viol", n_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fir_tdm_scheduler.md
FIR_TDM_SCHEDULER -- requirements
Module: fir_tdm_scheduler

Interface
REQ-001 SHALL have parameters: NTAPS, default 32, taps per channel; DW, default 16, sample width (Q15).
REQ-002 SHALL have ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- ch0_x  in  16  signed ch0 sample
- ch0_valid  in  1  ch0 sample offered
- ch0_ready  out  1  ch0 sample accepted this cycle
- ch1_x  in  16  signed ch1 sample
- ch1_valid  in  1  ch1 sample offered
- ch1_ready  out  1  ch1 sample accepted this cycle
- y_out  out  16  signed filtered sample
- y_ch  out  1  channel of y_out
- y_valid  out  1  y_out valid
- y_ready  in  1  consumer accepts y_out
- busy  out  1  state is not IDLE

Function
REQ-003 SHALL time-share one 17x16 multiplier and one 38-bit accumulator between two channels, each with its own 32x16 delay line.
REQ-004 SHALL implement states IDLE, MAC, SCALE, OUT.
REQ-005 In IDLE, chN_ready SHALL equal chN_valid AND grant==N (combinational); all other states drive both readys 0.
REQ-006 Grant SHALL be round-robin: if only one channel is valid, grant it; if both are valid, grant the channel not served last; pointer updates on each accept.
REQ-007 On accept, the sample SHALL shift into that channel's taps[0], with taps[k] <= taps[k-1].
REQ-008 Per-channel fill counter SHALL saturate at 32.
- If the post-accept count < 32: stay in IDLE, no output.
- Otherwise: go to MAC with k=0 and accumulator cleared.
REQ-009 MAC SHALL last exactly 16 cycles, k=0..15: acc += (taps[k]+taps[31-k]) (17-bit signed) * coeff[k] (16-bit signed Q15).
REQ-010 SCALE (1 cycle) SHALL compute acc >>> 15 (arithmetic) and saturate it to [-32768, 32767] into y_out; y_ch SHALL be the served channel.
REQ-011 OUT SHALL hold y_valid=1 with y_out and y_ch stable until y_ready=1, then return to IDLE; y_valid=0 in all other states.
REQ-012 Latency: accept at edge T SHALL give y_valid=1 from the cycle after edge T+17, with y_ready held high.
REQ-013 Samples offered while busy SHALL NOT be accepted; producers hold valid (no drop, no overwrite).
REQ-014 Back-to-back: with y_ready=1 and both channels valid, service SHALL alternate ch0, ch1, ch0..., one result per 19 cycles.
REQ-015 The MAC SHALL use the delay-line contents as they were after the accepting shift; the other channel's delay line SHALL be untouched.

Reset
REQ-016 reset_n low SHALL immediately force:
- state IDLE, rr pointer to ch0 priority
- fill counters 0, delay lines 0, accumulator 0
- y_out 0, y_ch 0, y_valid 0, busy 0, both readys 0 during reset
REQ-017 Reset mid-MAC or mid-OUT SHALL abandon the result with no y_valid pulse after release.

Structure
REQ-018 Shared package fir_pkg SHALL hold:
- NTAPS, NUNIQUE=16
- Q15 coefficient table coeff[0:15] = 0,-3,11,-27,39,-11,-98,277,-392,203,471,-1475,2137,-1328,-2638,19218 (sum over 32 taps = 32768)
- state enum type
- sat16 width constants
REQ-019 Delay-line storage SHALL be one sub-module, fir_delay_line: 32x16 shift register with shift enable and one indexed pair-sum read port; instantiated once per channel.

Verification
REQ-020 DC: 32 samples of +10000 on ch0 -> one y_valid, y_out=10000, y_ch=0; no output for the first 31.
REQ-021 Impulse: ch1 sends 16 zeros, then 16384, then 15 zeros -> y_out=9609 (16384*19218>>>15), y_ch=1, 18 cycles after the last accept.
REQ-022 Saturation: ch0 filled with +32767 where the aligned coeff>0 and -32768 where coeff<0 -> y_out=32767; the inverted pattern -> y_out=-32768.
REQ-023 Contention: both channels valid continuously after fill, y_ready=1 -> y_ch alternates 0,1,0,1; each channel's result matches the reference model; readys are never both high.
REQ-024 Backpressure/reset: hold y_ready=0 for 50 cycles -> y_out, y_ch stable, readys 0; pulse reset_n mid-MAC -> y_valid stays 0, fill counters restart (32 new samples needed).
